// File: rtl/fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fb_pkg                                                     |
// | Description : Shared constants and types for the framebuffer access      |
// |               scheduler: image geometry, fetch FSM encoding, read-tag    |
// |               source codes and a byte-lane extraction helper.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fb_pkg;

  // Default image box geometry (pixels), 4 pixels per 32-bit RAM word
  localparam int IMG_W           = 300;
  localparam int IMG_H           = 300;
  localparam int WORDS_PER_FRAME = IMG_W * IMG_H / 4;

  // Display fetch FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  // Source tag carried alongside every RAM read
  localparam logic SRC_DISP = 1'b0;
  localparam logic SRC_CPU  = 1'b1;

  // Little-endian pixel extraction: lane i is byte [8i+7:8i]
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_pixel_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fb_pixel_fifo                                              |
// | Description : Word FIFO for prefetched display data with a 32->8 byte    |
// |               unpacker on the read side.                                 |
// |   clk, reset  : clock, asynchronous active-high reset                    |
// |   flush       : empty the FIFO and rewind the byte lane                  |
// |   push/push_data : write one 32-bit word                                 |
// |   pop_req     : request one pixel                                        |
// |   count       : words currently stored                                   |
// |   pix_data/pix_valid : registered pixel, 1 cycle after pop_req           |
// |   empty_pop   : pop_req found the FIFO empty (combinational pulse)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fb_pixel_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic                       pop_req,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 pix_data,
  output logic                       pix_valid,
  output logic                       empty_pop
);
  import fb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       lane_q, lane_d;
  logic [7:0]       pix_data_q, pix_data_d;
  logic             pix_valid_q, pix_valid_d;
  logic             word_pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    lane_d      = lane_q;
    pix_data_d  = 8'd0;
    pix_valid_d = 1'b0;
    empty_pop   = 1'b0;
    word_pop    = 1'b0;

    if (pop_req) begin
      // An empty FIFO still answers with a valid zero pixel; the lane holds
      pix_valid_d = 1'b1;
      if (count_q == '0) begin
        empty_pop = 1'b1;
      end else begin
        pix_data_d = word_byte(mem_q[rd_ptr_q], lane_q);
        lane_d     = lane_q + 2'd1;
        word_pop   = (lane_q == 2'd3);
      end
    end

    if (push)     wr_ptr_d = wr_ptr_q + 1'b1;
    if (word_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !word_pop)      count_d = count_q + 1'b1;
    else if (!push && word_pop) count_d = count_q - 1'b1;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      lane_d      = 2'd0;
      pix_data_d  = 8'd0;
      pix_valid_d = 1'b0;
      empty_pop   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lane_q      <= 2'd0;
      pix_data_q  <= 8'd0;
      pix_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lane_q      <= lane_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  // Storage needs no reset; pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;

endmodule
`default_nettype wire

// File: rtl/fb_access_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fb_access_scheduler                                        |
// | Description : Shares a single-port 32-bit framebuffer RAM between the    |
// |               display prefetch and CPU accesses.                         |
// |   clk, reset            : clock, asynchronous active-high reset          |
// |   frame_start, pix_req  : from the VGA timing generator                  |
// |   pix_data, pix_valid   : pixel to the display, 1 cycle after pix_req    |
// |   underrun              : sticky per frame, a pix_req found no data      |
// |   cpu_req/we/addr/wdata : CPU request, held until cpu_ready              |
// |   cpu_ready             : combinational grant                            |
// |   cpu_rdata, cpu_rvalid : read return, 2 cycles after acceptance         |
// |   mem_addr/we/wdata     : registered RAM command                         |
// |   mem_rdata             : RAM read data, 1 cycle after mem_addr          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fb_access_scheduler #(
  parameter int IMG_W        = fb_pkg::IMG_W,
  parameter int IMG_H        = fb_pkg::IMG_H,
  parameter int ADDR_W       = 15,
  parameter int BASE_ADDR    = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int CPU_MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  import fb_pkg::*;

  localparam int WORDS  = IMG_W * IMG_H / 4;
  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

  localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [FCNT_W:0]   DEPTH_CMP = (FCNT_W + 1)'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(CPU_MAX_WAIT);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic              epoch_q, epoch_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              underrun_q, underrun_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Read tag pipeline: s1 = RAM sees the address, s2 = mem_rdata is valid
  logic s1_vld_q, s1_vld_d, s1_src_q, s1_src_d, s1_epoch_q, s1_epoch_d;
  logic s2_vld_q, s2_src_q, s2_epoch_q;

  logic [FCNT_W-1:0] fifo_count;
  logic [FCNT_W:0]   occupancy;
  logic              s1_disp, s2_disp;
  logic              disp_want, force_cpu, cpu_grant, disp_grant;
  logic              fifo_push, pop_req, empty_pop;

  assign s1_disp = s1_vld_q && (s1_src_q == SRC_DISP);
  assign s2_disp = s2_vld_q && (s2_src_q == SRC_DISP);

  // Arbitration. Reads still in the pipe count against FIFO space so a
  // granted fetch always finds room when its data returns.
  always_comb begin
    occupancy  = {1'b0, fifo_count} + {{FCNT_W{1'b0}}, s1_disp} + {{FCNT_W{1'b0}}, s2_disp};
    disp_want  = (state_q == ST_FETCH) && (occupancy < DEPTH_CMP);
    force_cpu  = cpu_req && (wait_cnt_q >= WAIT_MAX) && (fifo_count >= FCNT_W'(2));
    cpu_grant  = cpu_req && (force_cpu || !disp_want);
    disp_grant = disp_want && !force_cpu;
  end

  // Fetch FSM, address/word counters, CPU starvation counter, underrun
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    fetch_cnt_d  = fetch_cnt_q;
    epoch_d      = epoch_q;
    underrun_d   = underrun_q | empty_pop;
    wait_cnt_d   = wait_cnt_q;

    if (!cpu_req || cpu_grant)    wait_cnt_d = '0;
    else if (wait_cnt_q < WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;

    if (frame_start) begin
      // A fetch granted in this cycle carries the old epoch and is dropped
      state_d      = ST_FETCH;
      fetch_addr_d = BASE_WORD;
      fetch_cnt_d  = '0;
      epoch_d      = ~epoch_q;
      underrun_d   = 1'b0;
    end else if (disp_grant) begin
      fetch_addr_d = fetch_addr_q + 1'b1;
      fetch_cnt_d  = fetch_cnt_q + 1'b1;
      if (fetch_cnt_q == LAST_WORD) state_d = ST_DONE;
    end
  end

  // RAM command and read tag for the slot granted this cycle
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    s1_vld_d    = 1'b0;
    s1_src_d    = SRC_DISP;
    s1_epoch_d  = epoch_q;
    if (cpu_grant) begin
      mem_addr_d = cpu_addr;
      mem_we_d   = cpu_we;
      if (cpu_we) mem_wdata_d = cpu_wdata;
      s1_vld_d   = !cpu_we;
      s1_src_d   = SRC_CPU;
    end else if (disp_grant) begin
      mem_addr_d = fetch_addr_q;
      s1_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      fetch_cnt_q  <= '0;
      epoch_q      <= 1'b0;
      wait_cnt_q   <= '0;
      underrun_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      s1_vld_q     <= 1'b0;
      s1_src_q     <= SRC_DISP;
      s1_epoch_q   <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_src_q     <= SRC_DISP;
      s2_epoch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_cnt_q  <= fetch_cnt_d;
      epoch_q      <= epoch_d;
      wait_cnt_q   <= wait_cnt_d;
      underrun_q   <= underrun_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      s1_vld_q     <= s1_vld_d;
      s1_src_q     <= s1_src_d;
      s1_epoch_q   <= s1_epoch_d;
      s2_vld_q     <= s1_vld_q;
      s2_src_q     <= s1_src_q;
      s2_epoch_q   <= s1_epoch_q;
    end
  end

  // Display words fetched before the latest frame_start are discarded
  assign fifo_push = s2_disp && (s2_epoch_q == epoch_q);
  assign pop_req   = pix_req && !frame_start;

  fb_pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop_req   (pop_req),
    .count     (fifo_count),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .empty_pop (empty_pop)
  );

  assign underrun   = underrun_q;
  assign cpu_ready  = cpu_grant;
  assign cpu_rvalid = s2_vld_q && (s2_src_q == SRC_CPU);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire
